// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
//   Definitions shared by the SAR divider datapath and its BCD readout stage.
//   - sar_state_e : converter FSM states (IDLE, CONVERT)
//   - SAR_BITS    : default binary width produced by sar_divisor_module
//   - SAR_DIGITS  : default number of BCD digits (13 covers 2^40-1)
//   - DIGIT_W     : width of one packed BCD digit
// ---------------------------------------------------------------------------
package sar_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } sar_state_e;

  localparam int SAR_BITS   = 40;
  localparam int SAR_DIGITS = 13;
  localparam int DIGIT_W    = 4;

endpackage : sar_pkg

// File: rtl/bcd_add3_digit.sv
// ---------------------------------------------------------------------------
// bcd_add3_digit
//   Combinational correction step of the shift-and-add-3 algorithm. A digit
//   of 5 or more would become 10 or more after the next left shift, so it is
//   pre-corrected by +3, which makes the shift carry into the next digit.
// Ports:
//   digit_i  input  [DIGIT_W-1:0]  BCD digit before the shift
//   digit_o  output [DIGIT_W-1:0]  corrected digit (digit_i + 3 when >= 5)
// ---------------------------------------------------------------------------
module bcd_add3_digit
  import sar_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  output logic [DIGIT_W-1:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= DIGIT_W'(5)) begin
      digit_o = digit_i + DIGIT_W'(3);
    end
  end

endmodule : bcd_add3_digit

// File: rtl/sar_bcd_converter.sv
// ---------------------------------------------------------------------------
// sar_bcd_converter
//   Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock)
//   sitting behind sar_divisor_module. A rising edge on start captures binary
//   and converts it in BITS cycles; the previous result stays on bcd until the
//   new one is complete.
//
// Parameters:
//   BITS    width of the binary input (default SAR_BITS = 40)
//   DIGITS  number of packed BCD output digits (default SAR_DIGITS = 13)
// Ports:
//   clk       input   1          system clock, rising edge
//   reset     input   1          synchronous, active-low reset
//   start     input   1          level; only its rising edge starts a conversion
//   binary    input   BITS       value to convert, sampled on the trigger edge
//   bcd       output  4*DIGITS   packed BCD result, units in bcd[3:0]
//   ready     output  1          idle and bcd valid
//   overflow  output  1          only with SAR_BCD_OVERFLOW_EN: last result
//                                did not fit in DIGITS digits
//
// Configuration macro:
//   SAR_BCD_OVERFLOW_EN  adds the overflow port and its sticky flag; without
//                        it, excess high-order digits are silently truncated.
// ---------------------------------------------------------------------------
module sar_bcd_converter
  import sar_pkg::*;
#(
  parameter int BITS   = SAR_BITS,
  parameter int DIGITS = SAR_DIGITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [BITS-1:0]            binary,
  output logic [DIGIT_W*DIGITS-1:0]  bcd,
  output logic                       ready
`ifdef SAR_BCD_OVERFLOW_EN
  ,
  output logic                       overflow
`endif
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BITS + 1);

  sar_state_e        state_q, state_d;
  logic              start_q;
  logic [BITS-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]  bcd_sr_q, bcd_sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic              ready_q, ready_d;

  logic [BCD_W-1:0]  adjusted;
  logic [BCD_W-1:0]  bcd_shifted;
  logic [BITS-1:0]   bin_shifted;
  logic              shift_out;
  logic              trigger;

  // Per-digit +3 correction applied to the BCD register before each shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .digit_i (bcd_sr_q[g*DIGIT_W +: DIGIT_W]),
      .digit_o (adjusted[g*DIGIT_W +: DIGIT_W])
    );
  end

  // One left shift of the {bcd, bin} pair; the MSB of the top digit falls off.
  assign bcd_shifted = {adjusted[BCD_W-2:0], bin_sr_q[BITS-1]};
  assign bin_shifted = {bin_sr_q[BITS-2:0], 1'b0};
  assign shift_out   = adjusted[BCD_W-1];

  assign trigger = start & ~start_q;

`ifdef SAR_BCD_OVERFLOW_EN
  logic ovf_flag_q, ovf_flag_d;
  logic overflow_q, overflow_d;
`else
  // Truncated digits are intentionally dropped in this build.
  logic unused_shift_out;
  assign unused_shift_out = shift_out;
`endif

  // Next-state logic: load on trigger, shift BITS times, publish on the last.
  always_comb begin
    state_d  = state_q;
    bin_sr_d = bin_sr_q;
    bcd_sr_d = bcd_sr_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    ready_d  = ready_q;
`ifdef SAR_BCD_OVERFLOW_EN
    ovf_flag_d = ovf_flag_q;
    overflow_d = overflow_q;
`endif
    case (state_q)
      IDLE: begin
        if (trigger) begin
          bin_sr_d = binary;
          bcd_sr_d = '0;
          cnt_d    = CNT_W'(BITS);
          ready_d  = 1'b0;
          state_d  = CONVERT;
`ifdef SAR_BCD_OVERFLOW_EN
          ovf_flag_d = 1'b0;
`endif
        end
      end
      CONVERT: begin
        bin_sr_d = bin_shifted;
        bcd_sr_d = bcd_shifted;
        cnt_d    = cnt_q - CNT_W'(1);
`ifdef SAR_BCD_OVERFLOW_EN
        ovf_flag_d = ovf_flag_q | shift_out;
`endif
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = bcd_shifted;
          ready_d = 1'b1;
          state_d = IDLE;
`ifdef SAR_BCD_OVERFLOW_EN
          overflow_d = ovf_flag_q | shift_out;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // start_q keeps sampling during reset so a level held through reset
  // release is not seen as a fresh rising edge.
  always_ff @(posedge clk) begin
    start_q <= start;
    if (!reset) begin
      state_q  <= IDLE;
      bin_sr_q <= '0;
      bcd_sr_q <= '0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      ready_q  <= 1'b1;
`ifdef SAR_BCD_OVERFLOW_EN
      ovf_flag_q <= 1'b0;
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bin_sr_q <= bin_sr_d;
      bcd_sr_q <= bcd_sr_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      ready_q  <= ready_d;
`ifdef SAR_BCD_OVERFLOW_EN
      ovf_flag_q <= ovf_flag_d;
      overflow_q <= overflow_d;
`endif
    end
  end

  assign bcd   = bcd_q;
  assign ready = ready_q;
`ifdef SAR_BCD_OVERFLOW_EN
  assign overflow = overflow_q;
`endif

endmodule : sar_bcd_converter

// File: tb/tb_sar_bcd_converter.sv
// ---------------------------------------------------------------------------
// tb_sar_bcd_converter
//   Directed bench for sar_bcd_converter. Two instances share clock and reset:
//   the default 40-bit / 13-digit converter and a 10-bit / 3-digit one that
//   exercises truncation (and the overflow flag when SAR_BCD_OVERFLOW_EN is
//   defined). Expected values are hand-computed decimal results.
// ---------------------------------------------------------------------------
module tb_sar_bcd_converter;

  localparam int BITS     = 40;
  localparam int DIGITS   = 13;
  localparam int S_BITS   = 10;
  localparam int S_DIGITS = 3;

  logic                   clk;
  logic                   reset;
  logic                   start;
  logic [BITS-1:0]        binary;
  logic [4*DIGITS-1:0]    bcd;
  logic                   ready;
  logic                   s_start;
  logic [S_BITS-1:0]      s_binary;
  logic [4*S_DIGITS-1:0]  s_bcd;
  logic                   s_ready;
`ifdef SAR_BCD_OVERFLOW_EN
  logic                   ovf;
  logic                   s_ovf;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  sar_bcd_converter #(.BITS(BITS), .DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .binary   (binary),
    .bcd      (bcd),
    .ready    (ready)
`ifdef SAR_BCD_OVERFLOW_EN
    ,
    .overflow (ovf)
`endif
  );

  sar_bcd_converter #(.BITS(S_BITS), .DIGITS(S_DIGITS)) dut_small (
    .clk      (clk),
    .reset    (reset),
    .start    (s_start),
    .binary   (s_binary),
    .bcd      (s_bcd),
    .ready    (s_ready)
`ifdef SAR_BCD_OVERFLOW_EN
    ,
    .overflow (s_ovf)
`endif
  );

  // 10 ns clock with a free-running edge counter used for latency checks.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the big converter's inputs, then advance one edge and settle.
  task automatic applyStimulus(input logic s, input logic [BITS-1:0] b);
    start  = s;
    binary = b;
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for the big converter to return ready.
  task automatic waitReady(input int limit);
    int n;
    n = 0;
    while (!ready && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Full conversion on the big instance with latency and hold checks.
  task automatic runConversion(input string tag, input logic [BITS-1:0] value,
                               input logic [4*DIGITS-1:0] expected,
                               input logic [4*DIGITS-1:0] previous);
    int k;
    applyStimulus(1'b1, value);
    k = cyc;
    checkOutput({tag, "_ready_fall"}, 64'(ready), 64'(0));
    repeat (BITS - 2) begin
      @(posedge clk);
      #1;
    end
    checkOutput({tag, "_hold"}, 64'(bcd), 64'(previous));
    waitReady(20);
    checkOutput({tag, "_latency"}, 64'(cyc - k), 64'(BITS));
    checkOutput({tag, "_ready"}, 64'(ready), 64'(1));
    checkOutput({tag, "_bcd"}, 64'(bcd), 64'(expected));
  endtask

  // Full conversion on the small instance.
  task automatic runSmall(input string tag, input logic [S_BITS-1:0] value,
                          input logic [4*S_DIGITS-1:0] expected,
                          input logic exp_ovf);
    int k;
    int n;
    s_start  = 1'b1;
    s_binary = value;
    @(posedge clk);
    #1;
    k = cyc;
    n = 0;
    while (!s_ready && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 64'(cyc - k), 64'(S_BITS));
    checkOutput({tag, "_bcd"}, 64'(s_bcd), 64'(expected));
`ifdef SAR_BCD_OVERFLOW_EN
    checkOutput({tag, "_ovf"}, 64'(s_ovf), 64'(exp_ovf));
`else
    if (exp_ovf) begin
      checkOutput({tag, "_ready"}, 64'(s_ready), 64'(1));
    end
`endif
    s_start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int falls;
    logic prev_ready;

    reset    = 1'b0;
    start    = 1'b0;
    binary   = '0;
    s_start  = 1'b0;
    s_binary = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_bcd", 64'(bcd), 64'(0));
    checkOutput("rst_ready", 64'(ready), 64'(1));
    checkOutput("rst_small_ready", 64'(s_ready), 64'(1));
`ifdef SAR_BCD_OVERFLOW_EN
    checkOutput("rst_ovf", 64'(ovf), 64'(0));
`endif
    reset = 1'b1;
    applyStimulus(1'b0, '0);

    // Divider result 425332234 / 62254 = 6832.
    runConversion("div", 40'd6832, 52'h0000000006832, 52'h0);
    applyStimulus(1'b0, '0);

    // Extremes of the 40-bit range.
    runConversion("max", 40'hFF_FFFF_FFFF, 52'h1099511627775, 52'h0000000006832);
    applyStimulus(1'b0, '0);
    runConversion("zero", 40'd0, 52'h0, 52'h1099511627775);
    applyStimulus(1'b0, '0);

    // Held start: one conversion only across 100 high cycles.
    runConversion("held", 40'd77, 52'h77, 52'h0);
    falls = 0;
    prev_ready = ready;
    repeat (100 - BITS - 1) begin
      applyStimulus(1'b1, 40'd77);
      if (prev_ready && !ready) falls++;
      prev_ready = ready;
    end
    checkOutput("held_single", 64'(falls), 64'(0));
    checkOutput("held_bcd", 64'(bcd), 64'h77);
    applyStimulus(1'b0, 40'd77);

    // Pulses during CONVERT are neither accepted nor queued.
    applyStimulus(1'b1, 40'd4321);
    k = cyc;
    applyStimulus(1'b0, 40'd4321);
    applyStimulus(1'b0, 40'd999);
    applyStimulus(1'b1, 40'd999);
    applyStimulus(1'b0, 40'd999);
    applyStimulus(1'b1, 40'd999);
    applyStimulus(1'b0, 40'd999);
    checkOutput("pulse_hold", 64'(bcd), 64'h77);
    waitReady(BITS + 10);
    checkOutput("pulse_latency", 64'(cyc - k), 64'(BITS));
    checkOutput("pulse_bcd", 64'(bcd), 64'h4321);
    repeat (3) applyStimulus(1'b0, 40'd999);
    checkOutput("pulse_not_queued", 64'(ready), 64'(1));

    // Reset at edge k+20 aborts the conversion.
    applyStimulus(1'b1, 40'd5555);
    repeat (19) applyStimulus(1'b1, 40'd5555);
    checkOutput("abort_busy", 64'(ready), 64'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_ready", 64'(ready), 64'(1));
    checkOutput("abort_bcd", 64'(bcd), 64'(0));
    applyStimulus(1'b1, 40'd5555);
    reset = 1'b1;
    applyStimulus(1'b1, 40'd5555);
    applyStimulus(1'b1, 40'd5555);
    checkOutput("rst_release_no_trig", 64'(ready), 64'(1));
    applyStimulus(1'b0, 40'd5555);
    runConversion("after_abort", 40'd12345, 52'h12345, 52'h0);
    applyStimulus(1'b0, '0);

    // Small instance: 1000 does not fit in three digits, 999 does.
    runSmall("small_1000", 10'd1000, 12'h000, 1'b1);
    runSmall("small_999", 10'd999, 12'h999, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sar_bcd_converter
